// File: rtl/tt_pcpi_pkg.sv
// Shared definitions for the PCPI host link (inbound receiver and result transmitter).
package tt_pcpi_pkg;

    localparam int NIBBLE_W    = 4;
    localparam int NIBBLES_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_PRESENT = 2'd2,
        ST_RELEASE = 2'd3
    } link_state_e;

endpackage

// File: rtl/ack_synchronizer.sv
// Multi-flop synchroniser for the asynchronous host_ack pin; resets to 0.
module ack_synchronizer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pcpi_result_nibble_tx.sv
// Captures a PCPI result and sends it to the host as LSB-first nibbles using a
// 4-phase valid/ack handshake: valid rises, ack rises, valid falls, ack falls.
module pcpi_result_nibble_tx
    import tt_pcpi_pkg::*;
#(
    parameter int NIBBLES     = NIBBLES_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = NIBBLE_W * NIBBLES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pcpi_ready,
    input  logic                pcpi_wr,
    input  logic [DATA_W-1:0]   pcpi_rd,
    input  logic                host_ack,
    output logic [NIBBLE_W-1:0] tx_nibble,
    output logic                tx_valid,
    output logic                busy,
    output logic                done,
    output logic                overrun
);

    localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NIBBLES - 1);

    link_state_e          state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [NIBBLE_W-1:0]  nibble_d;
    logic                 valid_d, done_d, overrun_d, busy_d;
    logic                 ack_s;
    logic                 load;
    logic [CNT_W-1:0]     nib_idx;
    logic [NIBBLE_W-1:0]  sel_nibble;

    ack_synchronizer #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (host_ack),
        .q    (ack_s)
    );

    assign load = pcpi_ready & pcpi_wr;

    // Leaving RELEASE presents the following nibble, so look one index ahead there.
    always_comb begin
        nib_idx = count_q;
        if (state_q == ST_RELEASE) begin
            nib_idx = count_q + 1'b1;
        end
    end

    always_comb begin
        sel_nibble = data_q[NIBBLE_W-1:0];
        for (int i = 0; i < NIBBLES; i++) begin
            if (nib_idx == CNT_W'(i)) begin
                sel_nibble = data_q[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        data_d    = data_q;
        nibble_d  = tx_nibble;
        valid_d   = tx_valid;
        done_d    = 1'b0;
        overrun_d = overrun | (load & (state_q != ST_IDLE));
        unique case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                if (load) begin
                    data_d  = pcpi_rd;
                    count_d = '0;
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                // A host still holding ack from earlier must release it first.
                valid_d = 1'b0;
                if (!ack_s) begin
                    nibble_d = sel_nibble;
                    valid_d  = 1'b1;
                    state_d  = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (ack_s) begin
                    valid_d = 1'b0;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!ack_s) begin
                    if (count_q == LAST_IDX) begin
                        count_d = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        count_d  = count_q + 1'b1;
                        nibble_d = sel_nibble;
                        valid_d  = 1'b1;
                        state_d  = ST_PRESENT;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            data_q    <= '0;
            tx_nibble <= '0;
            tx_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            data_q    <= data_d;
            tx_nibble <= nibble_d;
            tx_valid  <= valid_d;
            busy      <= busy_d;
            done      <= done_d;
            overrun   <= overrun_d;
        end
    end

endmodule

// File: tb/tb_pcpi_result_nibble_tx.sv
// Directed bench: host model answers the handshake, monitor pops expected nibbles.
module tb_pcpi_result_nibble_tx;

    logic        clk;
    logic        rst_n;
    logic        pcpi_ready;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        host_ack;
    logic [3:0]  tx_nibble;
    logic        tx_valid;
    logic        busy;
    logic        done;
    logic        overrun;

    logic [3:0]  exp_q[$];
    int          n_checks;
    int          n_fail;
    int          mon_cnt;
    int          done_cnt;
    logic        host_auto;
    logic        prev_valid;

    pcpi_result_nibble_tx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pcpi_ready(pcpi_ready),
        .pcpi_wr   (pcpi_wr),
        .pcpi_rd   (pcpi_rd),
        .host_ack  (host_ack),
        .tx_nibble (tx_nibble),
        .tx_valid  (tx_valid),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Expected nibbles of a 32-bit result, LSB nibble first.
    task automatic push_exp(input logic [31:0] v);
        for (int i = 0; i < 8; i++) exp_q.push_back(v[i*4 +: 4]);
    endtask

    // Caller is at a negedge; load is sampled on the next posedge.
    task automatic do_load(input logic [31:0] v, input logic wr);
        pcpi_ready = 1'b1;
        pcpi_wr    = wr;
        pcpi_rd    = v;
        @(negedge clk);
        pcpi_ready = 1'b0;
        pcpi_wr    = 1'b0;
    endtask

    // Returns at the negedge where done is seen; checks busy fell with done.
    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got no done, want done within 400 cycles", name);
        end else begin
            check({name, "_busy_with_done"}, {31'd0, busy}, 32'd0);
        end
    endtask

    task automatic wait_nibbles(input int target);
        int n;
        n = 0;
        while (mon_cnt < target && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("nibble_wait", mon_cnt, target);
    endtask

    // host model
    initial begin
        forever begin
            @(negedge clk);
            if (host_auto) begin
                if (tx_valid && !host_ack) host_ack = 1'b1;
                else if (!tx_valid && host_ack) host_ack = 1'b0;
            end
        end
    end

    // scoreboard monitor
    initial begin
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (tx_valid && !prev_valid) begin
                mon_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_nibble", {28'd0, tx_nibble}, 32'hFFFF_FFFF);
                end else begin
                    check("nibble", {28'd0, tx_nibble}, {28'd0, exp_q.pop_front()});
                end
            end
            prev_valid = tx_valid;
        end
    end

    initial begin
        int d0;
        n_checks   = 0;
        n_fail     = 0;
        mon_cnt    = 0;
        done_cnt   = 0;
        host_auto  = 1'b1;
        host_ack   = 1'b0;
        pcpi_ready = 1'b0;
        pcpi_wr    = 1'b0;
        pcpi_rd    = '0;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_outputs", {busy, done, overrun, tx_valid, tx_nibble}, 32'd0);

        // 1: prompt host
        d0 = done_cnt;
        push_exp(32'hDEADBEEF);
        do_load(32'hDEADBEEF, 1'b1);
        check("t1_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("t1_latency_valid", {31'd0, tx_valid}, 32'd1);
        wait_done("t1");
        repeat (3) @(negedge clk);
        check("t1_done_once", done_cnt - d0, 32'd1);
        check("t1_overrun", {31'd0, overrun}, 32'd0);
        check("t1_queue_empty", exp_q.size(), 32'd0);

        // 2: stale ack held high at load
        host_auto = 1'b0;
        host_ack  = 1'b1;
        repeat (4) @(negedge clk);
        push_exp(32'hDEADBEEF);
        do_load(32'hDEADBEEF, 1'b1);
        repeat (8) @(negedge clk);
        check("t2_valid_held_low", {30'd0, busy, tx_valid}, 32'd2);
        host_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("t2_valid_still_low", {31'd0, tx_valid}, 32'd0);
        @(negedge clk);
        check("t2_valid_rises", {31'd0, tx_valid}, 32'd1);
        host_auto = 1'b1;
        wait_done("t2");
        repeat (2) @(negedge clk);
        check("t2_queue_empty", exp_q.size(), 32'd0);

        // 4: ready without wr is ignored
        do_load(32'h5555AAAA, 1'b0);
        repeat (6) @(negedge clk);
        check("t4_idle", {30'd0, busy, tx_valid}, 32'd0);

        // 3: second load while busy is dropped
        push_exp(32'hDEADBEEF);
        do_load(32'hDEADBEEF, 1'b1);
        repeat (10) @(negedge clk);
        do_load(32'h12345678, 1'b1);
        check("t3_overrun_set", {31'd0, overrun}, 32'd1);
        wait_done("t3");
        repeat (6) @(negedge clk);
        check("t3_overrun_sticky", {30'd0, overrun, busy}, 32'd2);
        check("t3_queue_empty", exp_q.size(), 32'd0);

        // 5: async reset mid-transfer
        d0 = mon_cnt;
        push_exp(32'h87654321);
        do_load(32'h87654321, 1'b1);
        wait_nibbles(d0 + 3);
        @(negedge clk);
        host_auto = 1'b0;
        #3 rst_n = 1'b0;
        #1 check("t5_async_reset", {busy, done, overrun, tx_valid, tx_nibble}, 32'd0);
        exp_q.delete();
        host_ack = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        host_auto = 1'b1;
        @(negedge clk);
        push_exp(32'h0000000A);
        do_load(32'h0000000A, 1'b1);
        wait_done("t5");
        repeat (2) @(negedge clk);
        check("t5_overrun_clear", {31'd0, overrun}, 32'd0);
        check("t5_queue_empty", exp_q.size(), 32'd0);

        // 6: load in the cycle done is visible
        d0 = done_cnt;
        push_exp(32'hCAFEF00D);
        do_load(32'hCAFEF00D, 1'b1);
        wait_done("t6a");
        push_exp(32'h0F1E2D3C);
        do_load(32'h0F1E2D3C, 1'b1);
        check("t6_accepted_busy", {31'd0, busy}, 32'd1);
        wait_done("t6b");
        repeat (3) @(negedge clk);
        check("t6_done_count", done_cnt - d0, 32'd2);
        check("t6_no_overrun", {31'd0, overrun}, 32'd0);
        check("t6_queue_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
